// File: rtl/pi_phase_controller_pkg.sv
// Shared types and defaults for the phase-interpolator loop controller.
//   PI_PHASE_W : default interpolator code width
//   pi_state_t : loop state (ACQ = acquisition, TRACK = tracking)
//   vote_t     : signed per-sample vote (-1, 0, +1)
package pi_ctrl_pkg;
  localparam int PI_PHASE_W = 6;

  typedef enum logic [0:0] {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } pi_state_t;

  typedef logic signed [1:0] vote_t;
endpackage

// File: rtl/pi_phase_controller_vote_integrator.sv
// Early/late vote integrator: decodes votes, sums them over a window of
// 2^WIN_LOG2 counted samples and reports the net sum on the closing sample.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clr           : synchronous clear of accumulator and window counter
//   count_en      : this cycle's vote is counted
//   early, late   : detector votes
//   win_close     : this counted sample closes the window (combinational)
//   net           : accumulator + current vote (valid when win_close)
module vote_integrator
  import pi_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 4,
  parameter int ACC_W    = WIN_LOG2 + 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    count_en,
  input  logic                    early,
  input  logic                    late,
  output logic                    win_close,
  output logic signed [ACC_W-1:0] net
);
  logic signed [ACC_W-1:0] acc;
  logic [WIN_LOG2-1:0]     cnt;
  vote_t                   v;

  // Both-high and both-low votes are neutral but still count.
  always_comb begin
    v = 2'sd0;
    if (early && !late)      v = 2'sd1;
    else if (late && !early) v = -2'sd1;
  end

  assign win_close = count_en && (&cnt);
  assign net       = acc + ACC_W'(v);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (count_en) begin
      if (win_close) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= net;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pi_phase_controller.sv
// Bang-bang loop controller producing the interpolator phase code.
// Integrates early/late votes per window and steps phase_sel by +/-1
// (modulo 2^PHASE_W) with an ACQ/TRACK state machine and lock detect.
// Ports:
//   base_clk, rst        : clock, synchronous active-high reset
//   vote_valid, early, late : detector votes
//   freeze               : hold phase and window progress
//   load_en, load_val    : software load of phase_sel
//   phase_sel            : registered interpolator code
//   step_up, step_dn     : one-cycle step pulses aligned with phase_sel change
//   locked               : TRACK with LOCK_CNT consecutive quiet windows
module pi_phase_controller
  import pi_ctrl_pkg::*;
#(
  parameter int PHASE_W  = PI_PHASE_W,
  parameter int WIN_LOG2 = 4,
  parameter int THRESH   = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic               base_clk,
  input  logic               rst,
  input  logic               vote_valid,
  input  logic               early,
  input  logic               late,
  input  logic               freeze,
  input  logic               load_en,
  input  logic [PHASE_W-1:0] load_val,
  output logic [PHASE_W-1:0] phase_sel,
  output logic               step_up,
  output logic               step_dn,
  output logic               locked
);
  localparam int ACC_W = WIN_LOG2 + 2;
  localparam int QW    = $clog2(LOCK_CNT + 1);
  localparam logic signed [ACC_W-1:0] THR_S = ACC_W'(THRESH);

  pi_state_t               state;
  vote_t                   last_dir;   // 0 = no step since reset/load
  logic [QW-1:0]           quiet;
  logic                    count_en, win_close, up, dn, reversal;
  logic signed [ACC_W-1:0] net, thr;
  vote_t                   dir;

  // Load outranks freeze; a closing sample under load never decides.
  assign count_en = vote_valid && !freeze && !load_en;

  vote_integrator #(.WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W)) u_integ (
    .clk      (base_clk),
    .rst      (rst),
    .clr      (load_en),
    .count_en (count_en),
    .early    (early),
    .late     (late),
    .win_close(win_close),
    .net      (net)
  );

  assign thr      = (state == TRACK) ? THR_S : '0;
  assign up       = win_close && (net > thr);
  assign dn       = win_close && (net < -thr);
  assign dir      = up ? 2'sd1 : -2'sd1;
  assign reversal = (last_dir != 2'sd0) && (last_dir != dir);
  assign locked   = (state == TRACK) && (quiet == QW'(LOCK_CNT));

  always_ff @(posedge base_clk) begin
    if (rst) begin
      phase_sel <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      state     <= ACQ;
      last_dir  <= 2'sd0;
      quiet     <= '0;
    end else if (load_en) begin
      phase_sel <= load_val;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      state     <= ACQ;
      last_dir  <= 2'sd0;
      quiet     <= '0;
    end else begin
      step_up <= up;
      step_dn <= dn;
      if (up || dn) begin
        phase_sel <= up ? phase_sel + PHASE_W'(1) : phase_sel - PHASE_W'(1);
        quiet     <= '0;
        last_dir  <= dir;
        if (reversal) state <= TRACK;
      end else if (win_close && state == TRACK && quiet != QW'(LOCK_CNT)) begin
        quiet <= quiet + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pi_phase_controller.sv
module tb_pi_phase_controller;
  logic       base_clk = 1'b0;
  logic       rst = 1'b0, vote_valid = 1'b0, early = 1'b0, late = 1'b0;
  logic       freeze = 1'b0, load_en = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] phase_sel;
  logic       step_up, step_dn, locked;

  int vecs = 0, errs = 0;
  logic mid_pulse, pre_locked;

  pi_phase_controller dut (
    .base_clk(base_clk), .rst(rst), .vote_valid(vote_valid), .early(early),
    .late(late), .freeze(freeze), .load_en(load_en), .load_val(load_val),
    .phase_sel(phase_sel), .step_up(step_up), .step_dn(step_dn), .locked(locked)
  );

  always #5 base_clk = ~base_clk;

  task automatic tick();
    @(posedge base_clk); #1;
  endtask

  task automatic do_load(input logic [5:0] v);
    load_en = 1'b1; load_val = v;
    tick();
    load_en = 1'b0;
  endtask

  // One full window: ne early, nl late, remainder neutral.
  task automatic win(input int ne, input int nl);
    mid_pulse = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vote_valid = 1'b1;
      early = (i < ne);
      late  = (i >= ne) && (i < ne + nl);
      if (i == 15) pre_locked = locked;
      tick();
      if (i < 15 && (step_up || step_dn)) mid_pulse = 1'b1;
    end
    vote_valid = 1'b0; early = 1'b0; late = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    vecs++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    vecs += 4;
    if (phase_sel !== 6'd0) begin errs++; $display("FAIL reset_phase: got %0d expected 0", phase_sel); end
    if (step_up !== 1'b0) begin errs++; $display("FAIL reset_up: got %b expected 0", step_up); end
    if (step_dn !== 1'b0) begin errs++; $display("FAIL reset_dn: got %b expected 0", step_dn); end
    if (locked !== 1'b0) begin errs++; $display("FAIL reset_locked: got %b expected 0", locked); end
  endtask

  task automatic test_first_step();
    win(16, 0);
    chk("first_mid_pulse", int'(mid_pulse), 0);
    chk("first_up", int'(step_up), 1);
    chk("first_dn", int'(step_dn), 0);
    chk("first_phase", int'(phase_sel), 1);
    chk("first_locked", int'(locked), 0);
    tick();
    chk("first_pulse_width", int'(step_up), 0);
    // Still ACQ: a net +1 window must step.
    win(1, 0);
    chk("first_acq_step", int'(phase_sel), 2);
  endtask

  task automatic test_wrap();
    do_load(6'd63);
    chk("wrap_load", int'(phase_sel), 63);
    chk("wrap_load_nopulse", int'(step_up | step_dn), 0);
    win(16, 0);
    chk("wrap_up_phase", int'(phase_sel), 0);
    chk("wrap_up_pulse", int'(step_up), 1);
    do_load(6'd0);
    win(0, 16);
    chk("wrap_dn_phase", int'(phase_sel), 63);
    chk("wrap_dn_pulse", int'(step_dn), 1);
    chk("wrap_dn_noup", int'(step_up), 0);
  endtask

  task automatic test_track();
    do_load(6'd10);
    win(16, 0); chk("trk_up1", int'(phase_sel), 11);
    win(16, 0); chk("trk_up2", int'(phase_sel), 12);
    win(0, 16); chk("trk_dn", int'(phase_sel), 11);
    chk("trk_dn_pulse", int'(step_dn), 1);
    win(9, 7);
    chk("trk_net2_hold", int'(phase_sel), 11);
    chk("trk_net2_nopulse", int'(step_up | step_dn), 0);
    win(9, 6);
    chk("trk_net3_step", int'(phase_sel), 12);
    chk("trk_net3_pulse", int'(step_up), 1);
  endtask

  task automatic test_lock();
    for (int w = 0; w < 8; w++) begin
      win(0, 0);
      if (w == 6) chk("lock_after7", int'(locked), 0);
    end
    chk("lock_after8", int'(locked), 1);
    chk("lock_phase_held", int'(phase_sel), 12);
    win(16, 0);
    chk("lock_pre_step", int'(pre_locked), 1);
    chk("lock_step_up", int'(step_up), 1);
    chk("lock_drop", int'(locked), 0);
    chk("lock_step_phase", int'(phase_sel), 13);
  endtask

  task automatic test_freeze();
    do_load(6'd20);
    mid_pulse = 1'b0;
    vote_valid = 1'b1; early = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_up || step_dn) mid_pulse = 1'b1;
    end
    freeze = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (step_up || step_dn) mid_pulse = 1'b1;
    end
    chk("frz_no_early_close", int'(mid_pulse), 0);
    chk("frz_phase_held", int'(phase_sel), 20);
    tick();
    vote_valid = 1'b0; early = 1'b0;
    chk("frz_close_up", int'(step_up), 1);
    chk("frz_close_phase", int'(phase_sel), 21);
  endtask

  task automatic test_load_close();
    do_load(6'd30);
    vote_valid = 1'b1; early = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    load_en = 1'b1; load_val = 6'd42;
    tick();
    load_en = 1'b0; vote_valid = 1'b0; early = 1'b0;
    chk("ldc_phase", int'(phase_sel), 42);
    chk("ldc_nopulse", int'(step_up | step_dn), 0);
    chk("ldc_locked", int'(locked), 0);
    // Counters cleared and ACQ: a fresh net +1 window closes on its 16th sample.
    win(1, 0);
    chk("ldc_fresh_mid", int'(mid_pulse), 0);
    chk("ldc_fresh_step", int'(phase_sel), 43);
  endtask

  task automatic test_reset_mid();
    do_load(6'd5);
    vote_valid = 1'b1; early = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    vote_valid = 1'b0; early = 1'b0;
    chk("rstm_phase", int'(phase_sel), 0);
    win(16, 0);
    chk("rstm_mid", int'(mid_pulse), 0);
    chk("rstm_step", int'(phase_sel), 1);
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_wrap();
    test_track();
    test_lock();
    test_freeze();
    test_load_close();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pi_phase_controller.md
# pi_phase_controller

Digital bang-bang loop controller that generates the 6-bit `phase_sel` code for `phase_interpolator`. It integrates early/late votes from the downstream phase detector over fixed windows and steps the interpolator code up or down by one, wrapping modulo 64. It provides an acquisition/tracking state machine, a lock indicator, a software load path and a freeze control. It sits in the clock-recovery loop between the phase detector and the interpolator.

## Interface
- `PHASE_W`, 6, width of `phase_sel`; code wraps modulo 2^PHASE_W.
- `WIN_LOG2`, 4, log2 of the number of valid votes per decision window (16).
- `THRESH`, 2, magnitude the window net vote must strictly exceed to step while in TRACK.
- `LOCK_CNT`, 8, consecutive step-free TRACK windows required before `locked` asserts.
- `base_clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `vote_valid`  in  1  `early`/`late` are sampled this cycle.
- `early`  in  1  detector vote: the sampling clock is early.
- `late`  in  1  detector vote: the sampling clock is late.
- `freeze`  in  1  ignore votes and hold `phase_sel`.
- `load_en`  in  1  force `phase_sel` to `load_val`.
- `load_val`  in  PHASE_W  code to load.
- `phase_sel`  out  PHASE_W  registered interpolator code.
- `step_up`  out  1  one-cycle pulse; `phase_sel` was incremented this cycle.
- `step_dn`  out  1  one-cycle pulse; `phase_sel` was decremented this cycle.
- `locked`  out  1  loop is locked.

## Operation
- Vote decoding per cycle with `vote_valid`=1 and `freeze`=0:
  - `early` & !`late` gives +1.
  - `late` & !`early` gives -1.
  - Both high or both low gives 0, and the sample still counts toward the window.
- Accumulator: signed, WIN_LOG2+2 bits. The window counter advances only on counted samples.
- Window close: the 2^WIN_LOG2-th counted sample. `net` = accumulator + current vote. The accumulator and counter clear in the closing cycle.
- Decision at close (threshold T = 0 in ACQ, T = THRESH in TRACK):
  - `net` > T: `phase_sel` +1, with 63 wrapping to 0.
  - `net` < -T: `phase_sel` -1, with 0 wrapping to 63.
  - Otherwise: hold.
- States: ACQ and TRACK.
  - Reset and `load_en` enter ACQ.
  - ACQ to TRACK when a step's direction is opposite to the previous step's direction. The last direction is remembered; it clears on reset and load.
  - TRACK stays in TRACK until reset or load.
- Lock:
  - A quiet counter increments, saturating at LOCK_CNT, on each TRACK window that closes without a step.
  - Any step clears the counter.
  - `locked` = TRACK && counter == LOCK_CNT.
- Freeze: votes are ignored, and the counter and accumulator hold. State and lock count are unchanged.
- Load: `phase_sel` <= `load_val`. The accumulator, window counter, quiet counter and last direction clear, and the state goes to ACQ. No step pulse is generated.
- Priority: `rst` > `load_en` > `freeze` > vote processing.

## Timing
- Reset values:
  - `phase_sel`=0, `step_up`=0, `step_dn`=0, `locked`=0.
  - State ACQ; accumulator, window counter and quiet counter all 0.
- Latency: `phase_sel` and the step pulse update on the edge after the closing sample (1 cycle), together in the same cycle.
- The step pulse is high exactly one cycle. `step_up` and `step_dn` are never high together.
- `locked` deasserts in the same cycle the step pulse asserts.
- Load: `phase_sel` = `load_val` on the cycle after `load_en`. `locked` is 0 that cycle.
- `load_en` on a closing cycle: the decision is discarded and the load wins.
- `freeze` on a closing cycle: the sample is not counted, so the window does not close.
- `rst` mid-window: all partial state is discarded, and outputs reach their reset values on the next edge.
- Minimum spacing between steps: 2^WIN_LOG2 valid cycles.

## Structure
- Package `pi_ctrl_pkg` holds:
  - `PHASE_W` default constant.
  - `pi_state_t` enum {ACQ, TRACK}.
  - `vote_t` signed 2-bit typedef.
- Sub-module `vote_integrator`: vote decode, accumulator, window counter. It outputs `win_close` and `net`.
- The top level holds the FSM, the `phase_sel` register, the lock counter and the load/freeze priority.

## Test plan
- Reset, then 16 cycles of `early`=1: exactly one `step_up` one cycle after the 16th sample, `phase_sel`=1, state ACQ, `locked`=0.
- `load_val`=63, then 16 early votes: `phase_sel` wraps to 0 with `step_up`. Load 0, then 16 late votes: `phase_sel`=63 with `step_dn`.
- Windows early, early, late: steps +1, +1, -1, and TRACK is entered on the reversal. A TRACK window of net +2 (9 early / 7 late) gives no step. Net +3 gives a step.
- In TRACK, feed 8 windows of balanced votes: `locked` rises after the 8th close. A following net +16 window gives `step_up` and `locked` dropping in the same cycle.
- `freeze` held for 20 cycles mid-window with `early`=1: no count advance and no step. The window resumes and closes at the correct total count.
- `load_en`=1 with `load_val`=42 on a closing cycle that would step: `phase_sel`=42, no step pulse, state ACQ, counters cleared.
